// File: rtl/multiword_add_pkg.sv
// Shared types and default sizing for the sliced multi-word adder/subtractor.
package multiword_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_SLICE = 16;

endpackage

// File: rtl/multiword_add_seq_cla_slice.sv
// SLICE-bit carry-lookahead adder built from 4-bit CLA cells, chained by
// group propagate/generate terms.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       pg,
  output logic       gg
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // Internal carries are fully expanded so no ripple path exists inside the cell.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign sum = p ^ c;
  assign pg  = &p;
  assign gg  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

module cla_slice #(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  localparam int NG = SLICE / 4;

  logic [NG-1:0] pgv;
  logic [NG-1:0] ggv;
  logic [NG:0]   gc;

  for (genvar i = 0; i < NG; i++) begin : g_cell
    cla4 u_cla4 (
      .a   (a[i*4 +: 4]),
      .b   (b[i*4 +: 4]),
      .cin (gc[i]),
      .sum (sum[i*4 +: 4]),
      .pg  (pgv[i]),
      .gg  (ggv[i])
    );
  end

  always_comb begin
    gc[0] = cin;
    for (int i = 0; i < NG; i++) begin
      gc[i+1] = ggv[i] | (pgv[i] & gc[i]);
    end
  end

  assign cout = gc[NG];

endmodule

// File: rtl/multiword_add_seq.sv
// Wide add/subtract sequencer: one shared CLA slice processes the operands
// least-significant slice first, linked by a registered carry.
module multiword_add_seq
  import multiword_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

  if ((WIDTH % SLICE) != 0) begin : g_bad_width
    $error("WIDTH must be an integer multiple of SLICE");
  end
  if ((SLICE % 4) != 0) begin : g_bad_slice
    $error("SLICE must be a multiple of 4");
  end

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic [SLICE-1:0]  slice_a;
  logic [SLICE-1:0]  slice_b;
  logic [SLICE-1:0]  slice_sum;
  logic              slice_cout;

  assign slice_a = a_q[int'(idx_q)*SLICE +: SLICE];
  assign slice_b = b_q[int'(idx_q)*SLICE +: SLICE];

  cla_slice #(.SLICE(SLICE)) u_cla (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // B is stored pre-inverted for subtraction, so RUN never needs to know the op.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = op_a;
          b_d     = op_b ^ {WIDTH{sub}};
          carry_d = sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[int'(idx_q)*SLICE +: SLICE] = slice_sum;
        carry_d = slice_cout;
        if (idx_q == LAST) begin
          cout_d  = slice_cout;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[SLICE-1] != a_q[WIDTH-1]);
          zero_d  = (result_d == '0);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign result      = result_q;
  assign cout        = cout_q;
  assign ovf         = ovf_q;
  assign zero        = zero_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Scoreboard bench for multiword_add_seq: stimulus pushes hand-computed
// expectations, a negedge monitor pops them on each result handshake.
module tb_multiword_add_seq;

  typedef struct {
    logic [63:0] res;
    logic        c;
    logic        o;
    logic        z;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        sub;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] result;
  logic        cout;
  logic        ovf;
  logic        zero;

  exp_t expQ[$];
  int   checks;
  int   errors;

  multiword_add_seq #(.WIDTH(64), .SLICE(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .cout        (cout),
    .ovf         (ovf),
    .zero        (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: each accepted result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_result", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("result", result, e.res);
        checkOutput("cout", {63'd0, cout}, {63'd0, e.c});
        checkOutput("ovf", {63'd0, ovf}, {63'd0, e.o});
        checkOutput("zero", {63'd0, zero}, {63'd0, e.z});
      end
    end
  end

  task automatic pushExpected(input logic [63:0] r, input logic c, input logic o, input logic z);
    exp_t e;
    e.res = r;
    e.c   = c;
    e.o   = o;
    e.z   = z;
    expQ.push_back(e);
  endtask

  task automatic issueCommand(input logic [63:0] a, input logic [63:0] b, input logic s);
    int n;
    op_a        = a;
    op_b        = b;
    sub         = s;
    start_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!start_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!start_ready) checkOutput("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    op_a        = ~a;
    op_b        = ~b;
    sub         = ~s;
  endtask

  task automatic waitLatency(input int expected);
    int n;
    n = 0;
    while (!res_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("latency", 64'(n), 64'(expected));
  endtask

  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic s,
                               input logic [63:0] r, input logic c, input logic o, input logic z);
    pushExpected(r, c, o, z);
    issueCommand(a, b, s);
    waitLatency(4);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    start_valid = 1'b0;
    op_a        = '0;
    op_b        = '0;
    sub         = 1'b0;
    res_ready   = 1'b1;
    #23;
    checkOutput("reset_start_ready", {63'd0, start_ready}, 64'd1);
    checkOutput("reset_res_valid", {63'd0, res_valid}, 64'd0);
    checkOutput("reset_result", result, 64'd0);
    checkOutput("reset_flags", {61'd0, cout, ovf, zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
    applyStimulus(64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
    applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    applyStimulus(64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    applyStimulus(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(64'h0000_FFFF_0000_0000, 64'h0000_0001_0000_0000, 1'b0,
                  64'h0001_0000_0000_0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1);

    // Backpressure: result held while a new command waits outside IDLE.
    res_ready = 1'b0;
    pushExpected(64'h1234_5678_9ABC_DF00, 1'b0, 1'b0, 1'b0);
    issueCommand(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0);
    waitLatency(4);
    op_a        = 64'h10;
    op_b        = 64'h20;
    sub         = 1'b0;
    start_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_result", result, 64'h1234_5678_9ABC_DF00);
      checkOutput("bp_res_valid", {63'd0, res_valid}, 64'd1);
      checkOutput("bp_start_ready", {63'd0, start_ready}, 64'd0);
      checkOutput("bp_flags", {61'd0, cout, ovf, zero}, 64'd0);
    end
    pushExpected(64'h30, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp_release_idle", {62'd0, start_ready, res_valid}, 64'b10);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    op_a        = 64'hDEAD;
    waitLatency(4);
    @(posedge clk);
    #1;

    // Reset mid-RUN: asynchronous abort between clock edges.
    issueCommand(64'h1111, 64'h2222, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_res_valid", {63'd0, res_valid}, 64'd0);
    checkOutput("abort_start_ready", {63'd0, start_ready}, 64'd1);
    checkOutput("abort_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(64'd3, 64'd4, 1'b0, 64'd7, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 50 && expQ.size() != 0; i++) @(posedge clk);
    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
